xosera_bus_master: RTL and testbench

Sequences 16-bit Xosera register accesses onto the 8-bit `xosera_*` host bus that feeds `xosera_main` in `top`. Two on-chip requesters share the bus through a round-robin arbiter. Each access becomes two byte cycles: the even/high byte first (`bytesel=0`), then the odd/low byte (`bytesel=1`). Each byte cycle has programmable setup, strobe and hold phases. The block replaces the external pins as the source of bus stimulus, so a future CPU or init ROM can program the video core.

---
 rtl/xosera_bus_pkg.sv | 27 ++
 rtl/xosera_rr_arb2.sv | 26 ++
 rtl/xosera_bus_master.sv | 134 +++++++++++++
 tb/tb_xosera_bus_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xosera_bus_pkg.sv
// Shared types and constants for the Xosera 8-bit host bus sequencer.
package xosera_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } bus_state_t;

    typedef struct packed {
        logic        rd_nwr;
        logic [3:0]  reg_num;
        logic [15:0] wdata;
    } xreq_t;

    localparam logic BYTESEL_EVEN = 1'b0;
    localparam logic BYTESEL_ODD  = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/xosera_rr_arb2.sv
// Two-way round-robin arbiter; last_grant favours the other requester on a tie.
module xosera_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
            else                grant = valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         last_grant <= 1'b1;
        else if (grant[0]) last_grant <= 1'b0;
        else if (grant[1]) last_grant <= 1'b1;
    end

endmodule

// File: rtl/xosera_bus_master.sv
// Turns 16-bit register accesses from two requesters into paired byte cycles
// (even byte first) with programmable setup/strobe/hold on the Xosera host bus.
module xosera_bus_master
    import xosera_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_rd_nwr,
    input  logic [3:0]  req0_reg,
    input  logic [15:0] req0_wdata,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_rd_nwr,
    input  logic [3:0]  req1_reg,
    input  logic [15:0] req1_wdata,
    output logic        rsp_valid,
    output logic        rsp_src,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        bus_cs_n,
    output logic        bus_rd_nwr,
    output logic [3:0]  bus_reg_num,
    output logic        bus_bytesel,
    output logic [7:0]  bus_data_o,
    input  logic [7:0]  bus_data_i,
    output logic        bus_data_oe
);

    localparam int PH_MAX = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int CNT_W  = $clog2(PH_MAX + 1);

    bus_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             phase_done;
    logic             byte_idx;
    xreq_t            txn, req_sel;
    logic             txn_src;
    logic [15:0]      rdata;
    logic [7:0]       data_last;
    logic [7:0]       byte_out;
    logic [1:0]       grant;
    logic             active;

    xosera_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state == IDLE && !reset),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    always_comb begin
        req_sel = grant[1] ? '{rd_nwr: req1_rd_nwr, reg_num: req1_reg, wdata: req1_wdata}
                           : '{rd_nwr: req0_rd_nwr, reg_num: req0_reg, wdata: req0_wdata};
    end

    always_comb begin
        phase_done = 1'b0;
        case (state)
            SETUP:   phase_done = (cnt == CNT_W'(SETUP_CYC - 1));
            STROBE:  phase_done = (cnt == CNT_W'(STROBE_CYC - 1));
            HOLD:    phase_done = (cnt == CNT_W'(HOLD_CYC - 1));
            default: phase_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|grant)    state_next = SETUP;
            SETUP:   if (phase_done) state_next = STROBE;
            STROBE:  if (phase_done) state_next = HOLD;
            HOLD:    if (phase_done) state_next = (byte_idx == BYTESEL_ODD) ? RESP : SETUP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction registers, phase counter and read capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            byte_idx  <= BYTESEL_EVEN;
            txn       <= '0;
            txn_src   <= 1'b0;
            rdata     <= '0;
            data_last <= '0;
        end else begin
            cnt <= (state_next != state) ? '0 : cnt + 1'b1;
            if (state == IDLE && |grant) begin
                txn      <= req_sel;
                txn_src  <= grant[1];
                byte_idx <= BYTESEL_EVEN;
                rdata    <= '0;
            end
            if (state == STROBE && phase_done && txn.rd_nwr) begin
                if (byte_idx == BYTESEL_EVEN) rdata[15:8] <= bus_data_i;
                else                          rdata[7:0]  <= bus_data_i;
            end
            if (state == HOLD && !txn.rd_nwr) data_last <= byte_out;
            if (state == HOLD && phase_done)  byte_idx  <= BYTESEL_ODD;
        end
    end

    // Idle bus keeps reg/bytesel/data from the last access, so no glitches reach Xosera
    always_comb begin
        active      = (state == SETUP) || (state == STROBE) || (state == HOLD);
        byte_out    = (byte_idx == BYTESEL_ODD) ? txn.wdata[7:0] : txn.wdata[15:8];
        bus_cs_n    = (state != STROBE);
        bus_rd_nwr  = active ? txn.rd_nwr : 1'b1;
        bus_data_oe = active && !txn.rd_nwr;
        bus_data_o  = bus_data_oe ? byte_out : data_last;
        bus_reg_num = txn.reg_num;
        bus_bytesel = byte_idx;
        rsp_valid   = (state == RESP);
        rsp_src     = txn_src;
        rsp_rdata   = (state == RESP && txn.rd_nwr) ? rdata : 16'h0000;
        busy        = (state != IDLE);
        req0_ready  = grant[0];
        req1_ready  = grant[1];
    end

endmodule

// File: tb/tb_xosera_bus_master.sv
// Directed and randomized bench for xosera_bus_master against a transaction-level model.
module tb_xosera_bus_master;

    localparam int S = 1, T = 2, H = 1, B = S + T + H;

    typedef struct { int acc; logic src; logic rd; logic [3:0] regn; logic [15:0] wd; } txn_t;
    typedef struct { int cyc; logic src; logic [15:0] rdata; } rsp_t;
    typedef struct { int start; int width; int gap; logic bytesel; logic [7:0] data;
                     logic oe; logic rdn; logic [3:0] regn; logic stable; } pulse_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic        v0 = 0, v1 = 0, rd0 = 0, rd1 = 0;
    logic [3:0]  reg0 = 0, reg1 = 0;
    logic [15:0] wd0 = 0, wd1 = 0;
    logic        r0, r1, rsp_valid, rsp_src, busy, cs_n, rd_nwr, bytesel, oe;
    logic [15:0] rsp_rdata;
    logic [3:0]  reg_num;
    logic [7:0]  data_o, data_i;
    logic [7:0]  rd_mem [16][2];

    logic        b_v0 = 0, b_v1 = 0, b_rd1 = 0;
    logic [3:0]  b_reg1 = 0;
    logic [15:0] b_wd0 = 0, b_wd1 = 0;
    logic        b_r0, b_r1, b_rsp_valid, b_rsp_src, b_busy, b_cs_n, b_rd_nwr, b_bytesel, b_oe;
    logic [15:0] b_rsp_rdata;
    logic [3:0]  b_reg_num;
    logic [7:0]  b_data_o;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data_i = rd_mem[reg_num][bytesel];

    xosera_bus_master dut (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_ready(r0), .req0_rd_nwr(rd0), .req0_reg(reg0), .req0_wdata(wd0),
        .req1_valid(v1), .req1_ready(r1), .req1_rd_nwr(rd1), .req1_reg(reg1), .req1_wdata(wd1),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_rdata(rsp_rdata), .busy(busy),
        .bus_cs_n(cs_n), .bus_rd_nwr(rd_nwr), .bus_reg_num(reg_num), .bus_bytesel(bytesel),
        .bus_data_o(data_o), .bus_data_i(data_i), .bus_data_oe(oe)
    );

    xosera_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(b_v0), .req0_ready(b_r0), .req0_rd_nwr(1'b0), .req0_reg(4'h7), .req0_wdata(b_wd0),
        .req1_valid(b_v1), .req1_ready(b_r1), .req1_rd_nwr(b_rd1), .req1_reg(b_reg1), .req1_wdata(b_wd1),
        .rsp_valid(b_rsp_valid), .rsp_src(b_rsp_src), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
        .bus_cs_n(b_cs_n), .bus_rd_nwr(b_rd_nwr), .bus_reg_num(b_reg_num), .bus_bytesel(b_bytesel),
        .bus_data_o(b_data_o), .bus_data_i(8'h00), .bus_data_oe(b_oe)
    );

    // Bus monitor: records each cs_n low pulse and each response
    rsp_t   rsp_q[$];
    pulse_t pulse_q[$];
    logic   in_pulse = 0;
    int     hi_run = 100;
    int     cur_start, cur_width, cur_gap;
    logic   cur_bytesel, cur_oe, cur_rdn, cur_stable;
    logic [7:0] cur_data;
    logic [3:0] cur_regn;

    always @(negedge clk) begin
        if (reset) begin
            in_pulse <= 1'b0;
            hi_run   <= 100;
        end else begin
            if (rsp_valid) rsp_q.push_back('{cyc, rsp_src, rsp_rdata});
            if (!cs_n) begin
                hi_run <= 0;
                if (!in_pulse) begin
                    in_pulse    <= 1'b1;
                    cur_start   <= cyc;
                    cur_width   <= 1;
                    cur_gap     <= hi_run;
                    cur_bytesel <= bytesel;
                    cur_data    <= data_o;
                    cur_oe      <= oe;
                    cur_rdn     <= rd_nwr;
                    cur_regn    <= reg_num;
                    cur_stable  <= 1'b1;
                end else begin
                    cur_width <= cur_width + 1;
                    if (data_o !== cur_data || bytesel !== cur_bytesel || oe !== cur_oe ||
                        rd_nwr !== cur_rdn || reg_num !== cur_regn)
                        cur_stable <= 1'b0;
                end
            end else begin
                hi_run <= hi_run + 1;
                if (in_pulse)
                    pulse_q.push_back('{cur_start, cur_width, cur_gap, cur_bytesel, cur_data,
                                        cur_oe, cur_rdn, cur_regn, cur_stable});
                in_pulse <= 1'b0;
            end
        end
    end

    txn_t exp_q[$];
    logic model_last = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_cs_n",    32'(cs_n), 1);
        chk("rst_rd_nwr",  32'(rd_nwr), 1);
        chk("rst_reg_num", 32'(reg_num), 0);
        chk("rst_bytesel", 32'(bytesel), 0);
        chk("rst_data_o",  32'(data_o), 0);
        chk("rst_oe",      32'(oe), 0);
        chk("rst_ready",   32'({r1, r0}), 0);
        chk("rst_rsp",     32'({rsp_valid, rsp_src}), 0);
        chk("rst_rdata",   32'(rsp_rdata), 0);
        chk("rst_busy",    32'(busy), 0);
    endtask

    // Holds the chosen valids until n accepts, checking arbitration order and spacing
    task automatic drive_accepts(input logic a0, input logic a1, input int n);
        int   got = 0;
        int   waited = 0;
        int   prev = 0;
        logic exp_src;
        @(posedge clk); #1;
        v0 = a0; v1 = a1;
        while (got < n && waited < 400) begin
            @(negedge clk);
            waited++;
            if (r0 || r1) begin
                exp_src = (v0 && v1) ? ~model_last : v1;
                chk("grant", 32'({r1, r0}), exp_src ? 32'd2 : 32'd1);
                if (got > 0) chk("ready_spacing", 32'(cyc - prev), 2 * B + 2);
                exp_q.push_back(exp_src ? '{cyc, 1'b1, rd1, reg1, wd1} : '{cyc, 1'b0, rd0, reg0, wd0});
                model_last = exp_src;
                prev = cyc;
                got++;
            end
        end
        if (got < n) chk("accept_timeout", 32'(got), 32'(n));
        @(posedge clk); #1;
        v0 = 0; v1 = 0;
    endtask

    task automatic drain();
        int     waited = 0;
        txn_t   e;
        rsp_t   r;
        pulse_t p;
        while (rsp_q.size() < exp_q.size() && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        chk("rsp_count", 32'(rsp_q.size()), 32'(exp_q.size()));
        chk("busy_idle", 32'(busy), 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                chk("rsp_latency", 32'(r.cyc - e.acc), 2 * B + 1);
                chk("rsp_src", 32'(r.src), 32'(e.src));
                chk("rsp_rdata", 32'(r.rdata),
                    e.rd ? 32'({rd_mem[e.regn][0], rd_mem[e.regn][1]}) : 32'd0);
            end
            for (int k = 0; k < 2; k++) begin
                if (pulse_q.size() > 0) begin
                    p = pulse_q.pop_front();
                    chk("pulse_start", 32'(p.start - e.acc), 32'(1 + S + k * B));
                    chk("pulse_width", 32'(p.width), T);
                    chk("pulse_bytesel", 32'(p.bytesel), 32'(k));
                    chk("pulse_oe", 32'(p.oe), 32'(!e.rd));
                    chk("pulse_rd_nwr", 32'(p.rdn), 32'(e.rd));
                    chk("pulse_reg", 32'(p.regn), 32'(e.regn));
                    chk("pulse_stable", 32'(p.stable), 1);
                    chk("pulse_gap_ok", 32'(p.gap >= S + H), 1);
                    if (!e.rd) chk("pulse_data", 32'(p.data), (k == 1) ? 32'(e.wd[7:0]) : 32'(e.wd[15:8]));
                end else begin
                    chk("pulse_missing", 32'(pulse_q.size()), 1);
                end
            end
        end
        chk("pulse_extra", 32'(pulse_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0, lows, falls, w, t;
        logic prev_cs;

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 2; j++)
                rd_mem[i][j] = 8'($urandom);

        v0 = 1;
        repeat (3) @(negedge clk);
        check_reset_state();
        v0 = 0;
        reset = 0;
        @(negedge clk);
        check_reset_state();

        // Write req0 reg 3 0xA55A
        rd0 = 0; reg0 = 4'd3; wd0 = 16'hA55A;
        drive_accepts(1, 0, 1);
        drain();

        // Read req1 reg 2 returning 0x12, 0x34
        rd_mem[2][0] = 8'h12; rd_mem[2][1] = 8'h34;
        rd1 = 1; reg1 = 4'd2;
        drive_accepts(0, 1, 1);
        drain();

        // Both requesters valid for four transactions
        rd0 = 0; reg0 = 4'd9;  wd0 = 16'h1357;
        rd1 = 0; reg1 = 4'd10; wd1 = 16'hBEEF;
        drive_accepts(1, 1, 4);
        drain();

        // req0 alone, repeated back to back
        rd0 = 1; reg0 = 4'd6;
        drive_accepts(1, 0, 4);
        drain();

        // Randomized requests with random requester sets
        for (int n = 0; n < 12; n++) begin
            logic [1:0] sel;
            rd0 = 1'($urandom_range(0, 1)); reg0 = 4'($urandom_range(0, 15)); wd0 = 16'($urandom);
            rd1 = 1'($urandom_range(0, 1)); reg1 = 4'($urandom_range(0, 15)); wd1 = 16'($urandom);
            sel = 2'($urandom_range(1, 3));
            drive_accepts(sel[0], sel[1], (sel == 2'b11) ? 2 : 1);
            drain();
        end

        // Longer timing on the second instance: 3-cycle strobes, response at cycle 15
        b_wd0 = 16'($urandom);
        @(posedge clk); #1;
        b_v0 = 1; w = 0;
        do begin @(negedge clk); w++; end while (!b_r0 && w < 50);
        c0 = cyc;
        chk("b_accept", 32'({b_r1, b_r0}), 1);
        @(posedge clk); #1;
        b_v0 = 0;
        lows = 0; falls = 0; prev_cs = 1; w = 0;
        do begin
            @(negedge clk);
            w++;
            if (!b_cs_n) lows++;
            if (!b_cs_n && prev_cs) begin
                falls++;
                chk("b_bus_fields", 32'({b_reg_num, b_rd_nwr, b_oe, b_bytesel}),
                    32'({4'h7, 1'b0, 1'b1, 1'(falls - 1)}));
                chk("b_data_o", 32'(b_data_o), (falls == 1) ? 32'(b_wd0[15:8]) : 32'(b_wd0[7:0]));
            end
            prev_cs = b_cs_n;
        end while (!b_rsp_valid && w < 50);
        chk("b_rsp_cycle", 32'(cyc - c0), 15);
        chk("b_rsp", 32'({b_rsp_valid, b_rsp_src, b_busy}), 32'(3'b101));
        chk("b_rsp_rdata", 32'(b_rsp_rdata), 0);
        chk("b_cs_low_cycles", 32'(lows), 6);
        chk("b_cs_pulses", 32'(falls), 2);

        // Reset during byte 1 strobe
        rd0 = 0; reg0 = 4'd5; wd0 = 16'($urandom);
        drive_accepts(1, 0, 1);
        t = exp_q[exp_q.size() - 1].acc + 1 + S + B;
        w = 0;
        while (cyc != t && w < 50) begin @(negedge clk); w++; end
        chk("pre_reset_strobe", 32'({cs_n, bytesel}), 32'(2'b01));
        #1 reset = 1;
        #1 check_reset_state();
        repeat (2) @(negedge clk);
        reset = 0;
        exp_q.delete();
        rsp_q.delete();
        pulse_q.delete();
        model_last = 1'b1;
        repeat (15) @(negedge clk);
        chk("no_rsp_after_reset", 32'(rsp_q.size()), 0);
        rd0 = 0; reg0 = 4'd1; wd0 = 16'h0F0F;
        rd1 = 1; reg1 = 4'd4;
        drive_accepts(1, 1, 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
